// File: rtl/video_timing_if.sv
// Raster timing bus: pixel enable and source pixel in, coordinates and the packed
// blank/sync/rgb stream out, plus the frame interrupt and frame counter.
interface video_timing_if #(
  parameter int unsigned HCW  = 9,
  parameter int unsigned VCW  = 9,
  parameter int unsigned RGBW = 18
);
  logic            ce;
  logic [RGBW-1:0] irgb;
  logic [HCW-1:0]  hcount;
  logic [VCW-1:0]  vcount;
  logic [1:0]      oblank;
  logic [1:0]      osync;
  logic [RGBW-1:0] orgb;
  logic            irq;
  logic [4:0]      frame;

  modport master (
    input  ce, irgb,
    output hcount, vcount, oblank, osync, orgb, irq, frame
  );

  modport slave (
    output ce, irgb,
    input  hcount, vcount, oblank, osync, orgb, irq, frame
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator: free-running H/V counters, blank/sync decode delayed to match
// the pixel source latency, blank-masked RGB, per-frame interrupt and frame counter.
module video_timing #(
  parameter int unsigned HCW        = 9,
  parameter int unsigned VCW        = 9,
  parameter int unsigned RGBW       = 18,
  parameter int unsigned HTOTAL     = 448,
  parameter int unsigned HBLANK_BEG = 320,
  parameter int unsigned HSYNC_BEG  = 344,
  parameter int unsigned HSYNC_END  = 376,
  parameter int unsigned HBLANK_END = 416,
  parameter int unsigned VTOTAL     = 312,
  parameter int unsigned VBLANK_BEG = 248,
  parameter int unsigned VSYNC_BEG  = 248,
  parameter int unsigned VSYNC_END  = 252,
  parameter int unsigned VBLANK_END = 256,
  parameter int unsigned INT_LINE   = 248,
  parameter int unsigned INT_HPOS   = 0,
  parameter int unsigned INT_LEN    = 64,
  parameter int unsigned LAT        = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  video_timing_if.master vid_io
);

  localparam int unsigned IcW = $clog2(INT_LEN + 2);

  localparam logic [HCW-1:0] HLast  = HCW'(HTOTAL - 1);
  localparam logic [VCW-1:0] VLast  = VCW'(VTOTAL - 1);
  localparam logic [HCW-1:0] IntH   = HCW'(INT_HPOS);
  localparam logic [VCW-1:0] IntV   = VCW'(INT_LINE);
  localparam logic [IcW-1:0] IntLen = IcW'(INT_LEN);

  logic            ce;
  logic [HCW-1:0]  h_q, h_d;
  logic [VCW-1:0]  v_q, v_d;
  logic [4:0]      frame_q, frame_d;
  logic            irq_q, irq_d;
  logic [IcW-1:0]  irq_cnt_q, irq_cnt_d;
  logic [1:0]      oblank_q, oblank_d;
  logic [1:0]      osync_q, osync_d;
  logic [RGBW-1:0] orgb_q, orgb_d;

  logic [HCW:0]    h_ext;
  logic [VCW:0]    v_ext;
  logic [1:0]      blank_raw, sync_raw;
  logic [1:0]      blank_dly, sync_dly;

  assign ce = vid_io.ce;

  // Counters and interrupt.
  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    frame_d   = frame_q;
    irq_d     = irq_q;
    irq_cnt_d = irq_cnt_q;
    if (ce) begin
      if (h_q == HLast) begin
        h_d = '0;
        if (v_q == VLast) begin
          v_d     = '0;
          frame_d = frame_q + 5'd1;
        end else begin
          v_d = v_q + VCW'(1);
        end
      end else begin
        h_d = h_q + HCW'(1);
      end

      // Trigger reloads the count even while already running.
      if (h_q == IntH && v_q == IntV) begin
        irq_cnt_d = IntLen;
        irq_d     = (INT_LEN != 0);
      end else if (irq_cnt_q != '0) begin
        irq_cnt_d = irq_cnt_q - IcW'(1);
        irq_d     = (irq_cnt_q != IcW'(1));
      end
    end
  end

  // Raw decode; zero-extended so an END equal to 2**width still compares correctly.
  assign h_ext = {1'b0, h_q};
  assign v_ext = {1'b0, v_q};

  always_comb begin
    blank_raw[0] = (h_ext >= (HCW+1)'(HBLANK_BEG)) && (h_ext < (HCW+1)'(HBLANK_END));
    sync_raw[0]  = (h_ext >= (HCW+1)'(HSYNC_BEG))  && (h_ext < (HCW+1)'(HSYNC_END));
    blank_raw[1] = (v_ext >= (VCW+1)'(VBLANK_BEG)) && (v_ext < (VCW+1)'(VBLANK_END));
    sync_raw[1]  = (v_ext >= (VCW+1)'(VSYNC_BEG))  && (v_ext < (VCW+1)'(VSYNC_END));
  end

  // Delay blank/sync to line up with the pixel source read latency.
  if (LAT == 0) begin : g_no_delay
    assign blank_dly = blank_raw;
    assign sync_dly  = sync_raw;
  end else begin : g_delay
    logic [1:0] blank_pipe_q [LAT];
    logic [1:0] sync_pipe_q  [LAT];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(LAT); i++) begin
          blank_pipe_q[i] <= 2'b11;
          sync_pipe_q[i]  <= 2'b00;
        end
      end else if (ce) begin
        blank_pipe_q[0] <= blank_raw;
        sync_pipe_q[0]  <= sync_raw;
        for (int i = 1; i < int'(LAT); i++) begin
          blank_pipe_q[i] <= blank_pipe_q[i-1];
          sync_pipe_q[i]  <= sync_pipe_q[i-1];
        end
      end
    end

    assign blank_dly = blank_pipe_q[LAT-1];
    assign sync_dly  = sync_pipe_q[LAT-1];
  end

  always_comb begin
    oblank_d = oblank_q;
    osync_d  = osync_q;
    orgb_d   = orgb_q;
    if (ce) begin
      oblank_d = blank_dly;
      osync_d  = sync_dly;
      orgb_d   = (|blank_dly) ? '0 : vid_io.irgb;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q       <= '0;
      v_q       <= '0;
      frame_q   <= '0;
      irq_q     <= 1'b0;
      irq_cnt_q <= '0;
      oblank_q  <= 2'b11;
      osync_q   <= 2'b00;
      orgb_q    <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      frame_q   <= frame_d;
      irq_q     <= irq_d;
      irq_cnt_q <= irq_cnt_d;
      oblank_q  <= oblank_d;
      osync_q   <= osync_d;
      orgb_q    <= orgb_d;
    end
  end

  assign vid_io.hcount = h_q;
  assign vid_io.vcount = v_q;
  assign vid_io.frame  = frame_q;
  assign vid_io.irq    = irq_q;
  assign vid_io.oblank = oblank_q;
  assign vid_io.osync  = osync_q;
  assign vid_io.orgb   = orgb_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-timing instance and a shrunken LAT=0 instance share
// ce/irgb and are compared every cycle against an arithmetic raster model.
module tb_video_timing;

  typedef struct packed {
    int htotal; int hbb; int hsb; int hse; int hbe;
    int vtotal; int vbb; int vsb; int vse; int vbe;
    int il; int ih; int ilen; int lat;
  } cfg_t;

  localparam cfg_t CA = '{htotal:448, hbb:320, hsb:344, hse:376, hbe:416,
                          vtotal:312, vbb:248, vsb:248, vse:252, vbe:256,
                          il:248, ih:0, ilen:64, lat:2};
  localparam cfg_t CB = '{htotal:20, hbb:12, hsb:14, hse:16, hbe:18,
                          vtotal:10, vbb:7, vsb:7, vse:8, vbe:9,
                          il:6, ih:5, ilen:30, lat:0};

  logic        clk, rst, ce;
  logic [17:0] irgb;
  int          n;
  logic [17:0] hist[$];
  int          tests, fails;

  video_timing_if va ();
  video_timing_if vb ();

  assign va.ce   = ce;
  assign va.irgb = irgb;
  assign vb.ce   = ce;
  assign vb.irgb = irgb;

  video_timing dut_a (.clk_i(clk), .rst_i(rst), .vid_io(va));

  video_timing #(
    .HTOTAL(20), .HBLANK_BEG(12), .HSYNC_BEG(14), .HSYNC_END(16), .HBLANK_END(18),
    .VTOTAL(10), .VBLANK_BEG(7), .VSYNC_BEG(7), .VSYNC_END(8), .VBLANK_END(9),
    .INT_LINE(6), .INT_HPOS(5), .INT_LEN(30), .LAT(0)
  ) dut_b (.clk_i(clk), .rst_i(rst), .vid_io(vb));

  logic [45:0] act_a, act_b;
  assign act_a = {va.hcount, va.vcount, va.frame, va.irq, va.oblank, va.osync, va.orgb};
  assign act_b = {vb.hcount, vb.vcount, vb.frame, vb.irq, vb.oblank, vb.osync, vb.orgb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {hcount, vcount, frame, irq, oblank, osync, orgb} after nn ce ticks from reset.
  function automatic logic [45:0] exp_vec(cfg_t c, int nn);
    int k, h, v, m, f;
    logic [1:0] b, s;
    logic irq;
    logic [17:0] rgb;
    f = c.htotal * c.vtotal;
    k = nn - 1 - c.lat;
    b = 2'b11;
    s = 2'b00;
    if (k >= 0) begin
      h = k % c.htotal;
      v = (k / c.htotal) % c.vtotal;
      b = {(v >= c.vbb && v < c.vbe), (h >= c.hbb && h < c.hbe)};
      s = {(v >= c.vsb && v < c.vse), (h >= c.hsb && h < c.hse)};
    end
    m   = nn - 1 - (c.il * c.htotal + c.ih);
    irq = (m >= 0) && ((m % f) < c.ilen);
    rgb = (nn == 0 || b != 2'b00) ? 18'h0 : hist[nn-1];
    return {9'(nn % c.htotal), 9'((nn / c.htotal) % c.vtotal), 5'((nn / f) % 32),
            irq, b, s, rgb};
  endfunction

  task automatic tick(input logic ce_v, input logic [17:0] rgb_v);
    ce   = ce_v;
    irgb = rgb_v;
    @(posedge clk);
    #1;
    if (ce_v && !rst) begin
      n++;
      hist.push_back(rgb_v);
    end
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    ce   = 1'b1;
    irgb = 18'h3ffff;
    n    = 0;
    hist.delete();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (act_a !== exp_vec(CA, 0)) begin
      fails++;
      $display("FAIL reset_a got=%h exp=%h", act_a, exp_vec(CA, 0));
    end
    tests++;
    if (act_b !== exp_vec(CB, 0)) begin
      fails++;
      $display("FAIL reset_b got=%h exp=%h", act_b, exp_vec(CB, 0));
    end
    rst = 1'b0;
  endtask

  task automatic test_line();
    int hsync_hi, rise_a, rise_b;
    logic pa, pb;
    hsync_hi = 0;
    rise_a   = -1;
    rise_b   = -1;
    pa       = va.oblank[0];
    pb       = vb.oblank[0];
    for (int i = 0; i < 900; i++) begin
      tick(1'b1, 18'($urandom));
      tests++;
      if (act_a !== exp_vec(CA, n)) begin
        fails++;
        $display("FAIL line_a n=%0d got=%h exp=%h", n, act_a, exp_vec(CA, n));
      end
      tests++;
      if (act_b !== exp_vec(CB, n)) begin
        fails++;
        $display("FAIL line_b n=%0d got=%h exp=%h", n, act_b, exp_vec(CB, n));
      end
      if (n <= 451 && va.osync[0]) hsync_hi++;
      if (rise_a < 0 && !pa && va.oblank[0]) rise_a = n;
      if (rise_b < 0 && !pb && vb.oblank[0]) rise_b = n;
      pa = va.oblank[0];
      pb = vb.oblank[0];
    end
    tests++;
    if (hsync_hi != 32) begin
      fails++;
      $display("FAIL hsync_width got=%0d exp=32", hsync_hi);
    end
    tests++;
    if (rise_a != 323) begin
      fails++;
      $display("FAIL hblank_rise_lat2 got=%0d exp=323", rise_a);
    end
    tests++;
    if (rise_b != 13) begin
      fails++;
      $display("FAIL hblank_rise_lat0 got=%0d exp=13", rise_b);
    end
  endtask

  task automatic test_ce_stall();
    while (n < 1100) tick(1'b1, 18'($urandom));
    for (int i = 0; i < 100; i++) begin
      tick(1'b0, 18'($urandom));
      tests++;
      if (act_a !== exp_vec(CA, n) || act_b !== exp_vec(CB, n)) begin
        fails++;
        $display("FAIL ce_hold n=%0d got=%h/%h exp=%h/%h", n, act_a, act_b,
                 exp_vec(CA, n), exp_vec(CB, n));
      end
    end
    for (int i = 0; i < 40; i++) begin
      tick(1'($urandom_range(1, 0)), 18'($urandom));
      tests++;
      if (act_a !== exp_vec(CA, n) || act_b !== exp_vec(CB, n)) begin
        fails++;
        $display("FAIL ce_resume n=%0d got=%h/%h exp=%h/%h", n, act_a, act_b,
                 exp_vec(CA, n), exp_vec(CB, n));
      end
    end
  endtask

  task automatic test_frames();
    int n0, edges, exp_edges, nb;
    logic prev;
    n0        = n;
    edges     = 0;
    exp_edges = 0;
    prev      = vb.irq;
    while (n < n0 + 33 * 200) begin
      nb = n;
      tick(($urandom_range(3, 0) != 0), 18'($urandom));
      if (n != nb && ((n - 1) % 200) == 125) exp_edges++;
      if (vb.irq && !prev) edges++;
      prev = vb.irq;
      tests++;
      if (act_b !== exp_vec(CB, n)) begin
        fails++;
        $display("FAIL frames_b n=%0d got=%h exp=%h", n, act_b, exp_vec(CB, n));
      end
      tests++;
      if (act_a !== exp_vec(CA, n)) begin
        fails++;
        $display("FAIL frames_a n=%0d got=%h exp=%h", n, act_a, exp_vec(CA, n));
      end
    end
    tests++;
    if (edges != exp_edges) begin
      fails++;
      $display("FAIL irq_per_frame got=%0d exp=%0d", edges, exp_edges);
    end
  endtask

  task automatic test_mask();
    logic [45:0] ea, eb;
    for (int i = 0; i < 1000; i++) begin
      tick(1'b1, 18'h3ffff);
      ea = exp_vec(CA, n);
      eb = exp_vec(CB, n);
      tests++;
      if (va.orgb !== ((ea[21:20] != 2'b00) ? 18'h0 : 18'h3ffff)) begin
        fails++;
        $display("FAIL mask_a n=%0d got=%h exp_blank=%b", n, va.orgb, ea[21:20]);
      end
      tests++;
      if (vb.orgb !== ((eb[21:20] != 2'b00) ? 18'h0 : 18'h3ffff)) begin
        fails++;
        $display("FAIL mask_b n=%0d got=%h exp_blank=%b", n, vb.orgb, eb[21:20]);
      end
    end
  endtask

  task automatic test_reset_mid();
    while (n < 50 * 448 + 100) begin
      tick(1'b1, 18'($urandom));
      tests++;
      if (act_a !== exp_vec(CA, n) || act_b !== exp_vec(CB, n)) begin
        fails++;
        $display("FAIL run_to_reset n=%0d got=%h/%h exp=%h/%h", n, act_a, act_b,
                 exp_vec(CA, n), exp_vec(CB, n));
      end
    end
    tests++;
    if (va.hcount !== 9'd100 || va.vcount !== 9'd50) begin
      fails++;
      $display("FAIL reset_point got=(%0d,%0d) exp=(100,50)", va.hcount, va.vcount);
    end
    #3;
    rst = 1'b1;
    n   = 0;
    hist.delete();
    #1;
    tests++;
    if (act_a !== exp_vec(CA, 0) || act_b !== exp_vec(CB, 0)) begin
      fails++;
      $display("FAIL reset_async got=%h/%h exp=%h/%h", act_a, act_b,
               exp_vec(CA, 0), exp_vec(CB, 0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 18'($urandom));
      tests++;
      if (act_a !== exp_vec(CA, n) || act_b !== exp_vec(CB, n)) begin
        fails++;
        $display("FAIL after_reset n=%0d got=%h/%h exp=%h/%h", n, act_a, act_b,
                 exp_vec(CA, n), exp_vec(CB, n));
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_line();
    test_ce_stall();
    test_frames();
    test_mask();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
- Raster timing generator: produces the packed blank/sync/rgb stream that the scandoubler consumes on its input side (bit 0 = horizontal, bit 1 = vertical, all active high).
- Free-running H/V counters step on a clock enable and expose the pixel coordinates to the pixel source.
- Blank/sync are delayed to match the source's fixed read latency, and RGB is masked to zero during blanking.
- Also generates the per-frame CPU interrupt and a frame counter for flash attributes.

Parameters:
HCW, 9, horizontal counter width
VCW, 9, vertical counter width
RGBW, 18, rgb width
HTOTAL, 448, pixels per line (counter wraps at HTOTAL-1)
HBLANK_BEG, 320, first blanked pixel
HSYNC_BEG, 344, first hsync pixel
HSYNC_END, 376, first pixel after hsync
HBLANK_END, 416, first pixel after hblank
VTOTAL, 312, lines per frame
VBLANK_BEG, 248, first blanked line
VSYNC_BEG, 248, first vsync line
VSYNC_END, 252, first line after vsync
VBLANK_END, 256, first line after vblank
INT_LINE, 248, line on which the interrupt starts
INT_HPOS, 0, pixel on which the interrupt starts
INT_LEN, 64, interrupt length in ce ticks
LAT, 2, pixel source read latency in ce ticks (0..7)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ce  in  1  pixel clock enable
irgb  in  RGBW  pixel from source, LAT ce ticks after its coordinate
hcount  out  HCW  current horizontal coordinate
vcount  out  VCW  current vertical coordinate
oblank  out  2  {vblank, hblank}
osync  out  2  {vsync, hsync}
orgb  out  RGBW  masked pixel
irq  out  1  frame interrupt, active high
frame  out  5  frame counter

Behaviour:
- All state advances only on clock edges where ce=1; with ce=0 every register holds.
- Reset (async assert, sync release) sets:
  - hcount=0, vcount=0, frame=0, irq=0, osync=00, oblank=11, orgb=0;
  - every delay-pipeline stage to blank=11, sync=00.
- Counters:
  - hcount increments; at HTOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from VTOTAL-1 to 0; frame increments on that same tick (5-bit natural wrap).
- Raw decode, combinational from the counters:
  - hblank = HBLANK_BEG<=hcount<HBLANK_END
  - hsync = HSYNC_BEG<=hcount<HSYNC_END
  - vblank and vsync use the same rule on vcount.
  - Ranges do not wrap. Legal parameters satisfy BEG<END<=TOTAL.
- Delay: raw blank/sync pass through a LAT-stage ce-gated shift register (LAT=0 means no stage).
- Output stage, one registered stage on each ce tick:
  - oblank <= delayed blank
  - osync <= delayed sync
  - orgb <= |delayed blank ? 0 : irgb
- Total latency: LAT+1 ce ticks from a counter value to the oblank/osync/orgb that correspond to it.
- hcount/vcount are the counter registers themselves (no delay).
- irq, down-counter style:
  - Loads INT_LEN and asserts irq on the ce tick where the counters equal (INT_LINE, INT_HPOS).
  - irq is registered, so it is high from the following cycle.
  - irq deasserts after exactly INT_LEN ce ticks.
  - A retrigger while irq is high reloads the count. Unreachable with legal parameters; it is defined only for robustness.
  - irq is not delayed by LAT.
- Reset mid-frame: all outputs return to their reset values immediately, independent of ce. The first post-reset ce tick advances hcount to 1.

Test Plan:
- Reset then 448 ce ticks: hcount 0..447→0, vcount 0→1; oblank[0] rises exactly LAT+1=3 ticks after hcount reaches 320 and falls 3 ticks after hcount reaches 416; osync[0] is high for 32 ticks.
- Full frame (448×312 ticks): vcount wraps 311→0; frame 0→1; osync[1] is high for 4×448 ticks starting 3 ticks after (248,0); oblank[1] is high for lines 248–255.
- irgb=all ones, constant: orgb=0 whenever oblank≠00, and all ones otherwise; no cycle is leaked at either blank edge.
- irq: asserted the cycle after (248,0) is counted, high for exactly 64 ce ticks, once per frame; 32 frames wrap frame to 0.
- ce held low for 100 cycles mid-line: no output or counter changes; resuming continues from the same hcount.
- reset asserted at (100,50) with ce=1: outputs go to oblank=11, osync=00, orgb=0, irq=0 at once; after release the counters restart at 0,0; a LAT=0 build shows blank 1 tick after the counter.
